cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the 64-bit simple CPU.
- Sequences each instruction through fetch, decode, execute and writeback, handshaking with instruction and data memory.
- Pulses the program counter's update enable and the register-file write enable once per retired instruction.
- Detects halt (SYSTEM opcode) and memory-timeout errors; supports single-step.

---
 rtl/cpu_sequencer.sv | 136 +++++++++++++
 tb/tb_cpu_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 64-bit simple CPU.
// Each instruction goes through FETCH, DECODE, EXEC and WB. The sequencer handshakes with
// instruction and data memory, and pulses the PC update and register-file write enables
// once per retired instruction. A SYSTEM opcode halts the core. A memory handshake that
// waits too long for ready moves the core to ERROR. Single-step mode is supported.
//
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   start, step_mode            run control (start is level-sampled in IDLE)
//   imem_req/ready/rdata        instruction fetch handshake
//   dmem_req/ready              data access handshake for loads and stores
//   instr                       instruction register
//   alu_zero, ctrl_branch       branch resolution inputs, used in WB
//   pc_update, branch_taken     PC enable pulse and PC select
//   rf_we                       register-file write enable pulse
//   state, retired              debug state and retired-instruction count
//   halted, error               sticky status (absorbing states)
module cpu_sequencer #(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                step_mode,
  output logic                imem_req,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic                dmem_req,
  input  logic                dmem_ready,
  output logic [31:0]         instr,
  input  logic                alu_zero,
  input  logic                ctrl_branch,
  output logic                pc_update,
  output logic                branch_taken,
  output logic                rf_we,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired,
  output logic                halted,
  output logic                error
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 1);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StError  = 3'd6
  } state_e;

  state_e                state_q;
  logic [31:0]           instr_q;
  logic [RETIRE_W-1:0]   retired_q;
  logic [CntW-1:0]       wait_q;

  logic [6:0] opcode;
  logic       is_mem;
  logic       writes_rd;

  assign opcode    = instr_q[6:0];
  assign is_mem    = (opcode == OpLoad) || (opcode == OpStore);
  assign writes_rd = (opcode != OpStore) && (opcode != OpBranch) && (instr_q[11:7] != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) state_q <= StFetch;
        end
        StFetch: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            wait_q  <= '0;
            state_q <= StDecode;
          end else if (wait_q == WaitLast) begin
            wait_q  <= '0;
            state_q <= StError;
          end else begin
            wait_q <= wait_q + CntW'(1);
          end
        end
        StDecode: begin
          state_q <= (opcode == OpSystem) ? StHalt : StExec;
        end
        StExec: begin
          // Non-memory ops spend a single cycle here. Loads and stores wait for dmem_ready
          // and use the same timeout as a fetch.
          if (!is_mem || dmem_ready) begin
            wait_q  <= '0;
            state_q <= StWb;
          end else if (wait_q == WaitLast) begin
            wait_q  <= '0;
            state_q <= StError;
          end else begin
            wait_q <= wait_q + CntW'(1);
          end
        end
        StWb: begin
          retired_q <= retired_q + RETIRE_W'(1);
          state_q   <= step_mode ? StIdle : StFetch;
        end
        StHalt, StError: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode directly from the state register. branch_taken follows the live
  // branch inputs because they are resolved during WB itself.
  assign imem_req     = (state_q == StFetch);
  assign dmem_req     = (state_q == StExec) && is_mem;
  assign pc_update    = (state_q == StWb);
  assign branch_taken = (state_q == StWb) && ctrl_branch && alu_zero;
  assign rf_we        = (state_q == StWb) && writes_rd;
  assign halted       = (state_q == StHalt);
  assign error        = (state_q == StError);
  assign state        = state_q;
  assign instr        = instr_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned RETIRE_W = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                step_mode;
  logic                imem_req;
  logic                imem_ready;
  logic [31:0]         imem_rdata;
  logic                dmem_req;
  logic                dmem_ready;
  logic [31:0]         instr;
  logic                alu_zero;
  logic                ctrl_branch;
  logic                pc_update;
  logic                branch_taken;
  logic                rf_we;
  logic [2:0]          state;
  logic [RETIRE_W-1:0] retired;
  logic                halted;
  logic                error;

  cpu_sequencer #(.TIMEOUT(TIMEOUT), .RETIRE_W(RETIRE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .step_mode    (step_mode),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .instr        (instr),
    .alu_zero     (alu_zero),
    .ctrl_branch  (ctrl_branch),
    .pc_update    (pc_update),
    .branch_taken (branch_taken),
    .rf_we        (rf_we),
    .state        (state),
    .retired      (retired),
    .halted       (halted),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Expected retire events, in order.
  typedef struct {
    logic [31:0] ins;
    logic        br;
    logic        we;
    logic [31:0] ret;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned model_retired = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A retire writes rd unless the instruction is a store or a branch, or rd is x0.
  function automatic logic model_we(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return !(op == 7'b0100011 || op == 7'b1100011) && (ins[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       op = 7'b0010011;
      1:       op = 7'b0110011;
      2:       op = 7'b0000011;
      3:       op = 7'b0100011;
      4:       op = 7'b1100011;
      default: op = 7'b0110111;
    endcase
    if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
    r[6:0] = op;
    return r;
  endfunction

  // Memory side of one instruction. The task returns during the DECODE cycle for
  // non-memory ops, and during the WB cycle for loads and stores.
  task automatic do_instr(input logic [31:0] ins, input int iw, input int dw,
                          input logic cb, input logic az);
    exp_t e;
    bit   mem;
    int   guard;
    mem   = (ins[6:0] == 7'b0000011) || (ins[6:0] == 7'b0100011);
    guard = 0;
    while (!imem_req && guard < 50) begin
      tick();
      guard++;
    end
    check("fetch_request_seen", imem_req, 1);
    if (!imem_req) return;
    ctrl_branch = cb;
    alu_zero    = az;
    if (ins[6:0] != 7'b1110011) begin
      e.ins    = ins;
      e.br     = cb & az;
      e.we     = model_we(ins);
      e.ret    = model_retired;
      e.cycles = 4 + iw + (mem ? dw : 0);
      model_retired++;
      sb.push_back(e);
    end
    repeat (iw) begin
      imem_ready = 1'b0;
      dmem_ready = 1'($urandom);
      tick();
    end
    imem_ready = 1'b1;
    imem_rdata = ins;
    dmem_ready = 1'($urandom);
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    dmem_ready = 1'b0;
    if (mem) begin
      tick();
      repeat (dw) begin
        dmem_ready = 1'b0;
        imem_ready = 1'($urandom);
        tick();
      end
      dmem_ready = 1'b1;
      imem_ready = 1'($urandom);
      tick();
      dmem_ready = 1'b0;
      imem_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_retired = 0;
  endtask

  // Monitor: pops one expectation for each pc_update pulse and times each instruction.
  initial begin
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || state == 3'd0 || state >= 3'd5) cyc = 0;
      else cyc++;
      if (rst_n && pc_update) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pc_update: got pulse in state %0d, required none", state);
        end else begin
          e = sb.pop_front();
          check("wb_instr", instr, e.ins);
          check("wb_branch_taken", branch_taken, e.br);
          check("wb_rf_we", rf_we, e.we);
          check("wb_retired", retired, e.ret);
          check("wb_cycle_count", cyc, e.cycles);
        end
        cyc = 0;
      end
      if (rst_n && rf_we) check("rf_we_only_with_pc_update", pc_update, 1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    int fcnt;
    int guard;
    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    alu_zero = 1'b0; ctrl_branch = 1'b0; imem_rdata = '0;
    tick();
    tick();
    @(negedge clk);
    check("reset_flags", {state, imem_req, dmem_req, pc_update, rf_we, branch_taken, halted, error},
          0);
    check("reset_retired", retired, 0);
    check("reset_instr", instr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("idle_without_start", state, 0);

    // Free-running directed and random instructions, then ECALL.
    tick();
    start = 1'b1;
    do_instr(32'h00100093, 0, 0, 1'b0, 1'b0);
    do_instr(32'h00000063, 0, 0, 1'b1, 1'b1);
    do_instr(32'h00000063, 0, 0, 1'b1, 1'b0);
    do_instr(32'h0000A103, 0, 3, 1'b0, 1'b0);
    do_instr(32'h0020A023, 2, 1, 1'b1, 1'b1);
    do_instr(32'h00100093, 15, 0, 1'b0, 1'b1);
    do_instr(32'h0000A103, 15, 15, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      do_instr(rand_instr(), $urandom_range(0, 15), $urandom_range(0, 15),
               1'($urandom), 1'($urandom));
    end
    do_instr(32'h00000073, $urandom_range(0, 3), 0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    check("halt_state", state, 5);
    check("halt_flag", halted, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      start = 1'(i);
      imem_ready = 1'b1;
    end
    @(negedge clk);
    check("halt_absorbing", state, 5);
    check("halt_retired_unchanged", retired, model_retired);
    check("halt_no_imem_req", imem_req, 0);
    tick();
    imem_ready = 1'b0;

    // Fetch timeout.
    do_reset();
    start = 1'b1;
    fcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state == 3'd6) break;
      if (state == 3'd1) fcnt++;
    end
    check("fetch_timeout_cycles", fcnt, TIMEOUT);
    check("fetch_timeout_error", error, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'(i);
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
    end
    @(negedge clk);
    check("error_sticky", {state, error}, {3'd6, 1'b1});
    check("error_no_requests", {imem_req, dmem_req}, 0);
    tick();
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    do_reset();
    @(negedge clk);
    check("reset_clears_error", {state, error}, 0);

    // Data-memory timeout on a load.
    tick();
    start = 1'b1;
    guard = 0;
    while (!imem_req && guard < 10) begin
      tick();
      guard++;
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h0000A103;
    tick();
    imem_ready = 1'b0;
    fcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state == 3'd6) break;
      if (state == 3'd3) fcnt++;
    end
    check("dmem_timeout_cycles", fcnt, TIMEOUT);
    check("dmem_timeout_state", {error, dmem_req}, 2'b10);

    // Single-step mode.
    tick();
    start = 1'b0;
    step_mode = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      do_instr(rand_instr(), $urandom_range(0, 4), $urandom_range(0, 4),
               1'($urandom), 1'($urandom));
      guard = 0;
      while (state != 3'd0 && guard < 40) begin
        tick();
        guard++;
      end
      repeat (3) tick();
      @(negedge clk);
      check("step_returns_idle", state, 0);
      check("step_retired", retired, model_retired);
    end

    // Reset in the middle of a fetch, with a late ready that must be ignored.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    @(negedge clk);
    check("mid_fetch_req", imem_req, 1);
    tick();
    rst_n = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h00100093;
    @(posedge clk);
    @(negedge clk);
    check("mid_fetch_reset_state", {state, imem_req}, 0);
    check("mid_fetch_reset_instr", instr, 0);
    check("mid_fetch_reset_retired", retired, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("late_ready_ignored", {state, imem_req, instr}, 0);
    tick();
    imem_ready = 1'b0;

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
